fp_align_shift: RTL and testbench

- Pipelined mantissa alignment (denormalising) right-shifter. It is the counterpart of the leading-zero normaliser.
- Takes a 24-bit mantissa, its exponent and a right-shift amount. Produces the shifted mantissa, guard/round/sticky bits and the adjusted exponent.
- Sits ahead of the mantissa adder in the FP add path: the smaller operand is aligned to the larger exponent.
- Two register stages with valid/ready handshake on both sides.

---
 rtl/fp_align_shift_if.sv | 30 +++
 rtl/fp_align_shift.sv | 199 +++++++++++++++++++
 tb/tb_fp_align_shift.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_align_shift_if.sv
// Handshake bundle for the fp_align_shift mantissa alignment shifter.
// The master side drives inputs and out_ready. The slave side is the shifter itself.
interface fp_align_shift_if #(
  parameter int MW = 24,
  parameter int EW = 8,
  parameter int SW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic [SW-1:0] in_shift;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic          out_guard;
  logic          out_round;
  logic          out_sticky;
  logic [EW-1:0] out_exp;

  modport master (
    output in_valid, in_mant, in_exp, in_shift, out_ready,
    input  in_ready, out_valid, out_mant, out_guard, out_round, out_sticky, out_exp
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_shift, out_ready,
    output in_ready, out_valid, out_mant, out_guard, out_round, out_sticky, out_exp
  );
endinterface

// File: rtl/fp_align_shift.sv
// Two-stage mantissa alignment right-shifter with guard/round/sticky and saturating exponent.
// Optional macro ALIGN_STAT_EN adds a saturating count of inexact output transfers (stat_inexact).
module fp_align_shift #(
  parameter int MW = 24,
  parameter int EW = 8,
  parameter int SW = 8
) (
  input logic             clk,
  input logic             rst_n,
  fp_align_shift_if.slave bus
`ifdef ALIGN_STAT_EN
  ,
  output logic [15:0]     stat_inexact
`endif
);

  // Working field is the mantissa plus two extra low bits that become guard and round.
  localparam int FW = MW + 2;
  localparam int XW = EW + 1;

  logic adv1;
  logic adv2;

  logic          s1_valid_q, s1_valid_d;
  logic [MW-1:0] s1_mant_q,  s1_mant_d;
  logic [EW-1:0] s1_exp_q,   s1_exp_d;
  logic [SW-1:0] s1_shift_q, s1_shift_d;
  logic [FW-1:0] s1_field_q, s1_field_d;
  logic          s1_psticky_q, s1_psticky_d;
  logic          s1_flush_q, s1_flush_d;

  logic          s2_valid_q,  s2_valid_d;
  logic [MW-1:0] s2_mant_q,   s2_mant_d;
  logic          s2_guard_q,  s2_guard_d;
  logic          s2_round_q,  s2_round_d;
  logic          s2_sticky_q, s2_sticky_d;
  logic [EW-1:0] s2_exp_q,    s2_exp_d;

  assign adv2         = !s2_valid_q || bus.out_ready;
  assign adv1         = !s1_valid_q || adv2;
  assign bus.in_ready = adv1;

  logic [FW-1:0] ext_field;
  logic [4:0]    coarse_amt;
  logic [FW-1:0] coarse_field;
  logic          coarse_sticky;
  logic          flush_in;

  // Coarse stage: byte-granular shift; anything pushed past bit 0 folds into a partial sticky.
  always_comb begin
    ext_field     = {bus.in_mant, 2'b00};
    coarse_amt    = {bus.in_shift[4:3], 3'b000};
    coarse_field  = ext_field >> coarse_amt;
    coarse_sticky = |(ext_field & ~({FW{1'b1}} << coarse_amt));
    flush_in      = bus.in_shift >= SW'(FW);
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_mant_d    = s1_mant_q;
    s1_exp_d     = s1_exp_q;
    s1_shift_d   = s1_shift_q;
    s1_field_d   = s1_field_q;
    s1_psticky_d = s1_psticky_q;
    s1_flush_d   = s1_flush_q;
    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_mant_d    = bus.in_mant;
        s1_exp_d     = bus.in_exp;
        s1_shift_d   = bus.in_shift;
        s1_field_d   = coarse_field;
        s1_psticky_d = coarse_sticky;
        s1_flush_d   = flush_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mant_q    <= '0;
      s1_exp_q     <= '0;
      s1_shift_q   <= '0;
      s1_field_q   <= '0;
      s1_psticky_q <= 1'b0;
      s1_flush_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mant_q    <= s1_mant_d;
      s1_exp_q     <= s1_exp_d;
      s1_shift_q   <= s1_shift_d;
      s1_field_q   <= s1_field_d;
      s1_psticky_q <= s1_psticky_d;
      s1_flush_q   <= s1_flush_d;
    end
  end

  logic [2:0]    fine_amt;
  logic [FW-1:0] fine_field;
  logic [6:0]    lost_bits;
  logic [XW-1:0] exp_sum;
  logic [EW-1:0] exp_sat;
  logic [MW-1:0] res_mant;
  logic          res_guard;
  logic          res_round;
  logic          res_sticky;

  assign fine_amt   = s1_shift_q[2:0];
  assign fine_field = s1_field_q >> fine_amt;

  // Fine shift drops at most seven low bits; each one feeds the sticky if it falls off.
  for (genvar gi = 0; gi < 7; gi++) begin : g_lost
    assign lost_bits[gi] = s1_field_q[gi] & (fine_amt > 3'(gi));
  end

  assign exp_sum = XW'(s1_exp_q) + XW'(s1_shift_q);
  assign exp_sat = exp_sum[EW] ? {EW{1'b1}} : exp_sum[EW-1:0];

  always_comb begin
    res_mant   = fine_field[FW-1:2];
    res_guard  = fine_field[1];
    res_round  = fine_field[0];
    res_sticky = s1_psticky_q | (|lost_bits);
    if (s1_flush_q) begin
      res_mant   = '0;
      res_guard  = 1'b0;
      res_round  = 1'b0;
      res_sticky = |s1_mant_q;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_mant_d   = s2_mant_q;
    s2_guard_d  = s2_guard_q;
    s2_round_d  = s2_round_q;
    s2_sticky_d = s2_sticky_q;
    s2_exp_d    = s2_exp_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mant_d   = res_mant;
        s2_guard_d  = res_guard;
        s2_round_d  = res_round;
        s2_sticky_d = res_sticky;
        s2_exp_d    = exp_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_mant_q   <= '0;
      s2_guard_q  <= 1'b0;
      s2_round_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_exp_q    <= '0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_mant_q   <= s2_mant_d;
      s2_guard_q  <= s2_guard_d;
      s2_round_q  <= s2_round_d;
      s2_sticky_q <= s2_sticky_d;
      s2_exp_q    <= s2_exp_d;
    end
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.out_mant   = s2_mant_q;
  assign bus.out_guard  = s2_guard_q;
  assign bus.out_round  = s2_round_q;
  assign bus.out_sticky = s2_sticky_q;
  assign bus.out_exp    = s2_exp_q;

`ifdef ALIGN_STAT_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (bus.out_valid && bus.out_ready && (s2_guard_q | s2_round_q | s2_sticky_q)
        && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_inexact = stat_q;
`endif

endmodule

// File: tb/tb_fp_align_shift.sv
// Scoreboard bench for fp_align_shift: expected results are queued on accept and
// compared as outputs are transferred.
module tb_fp_align_shift;
  localparam int MW = 24;
  localparam int EW = 8;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_align_shift_if #(.MW(MW), .EW(EW), .SW(SW)) bus ();
`ifdef ALIGN_STAT_EN
  logic [15:0] stat_inexact;
`endif

  fp_align_shift #(.MW(MW), .EW(EW), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALIGN_STAT_EN
    ,
    .stat_inexact (stat_inexact)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int stat_model = 0;
  logic [34:0] sb[$];
  logic [34:0] mon_got;
  logic [34:0] mon_exp;
  bit rand_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference built straight from the bit-level definition of the alignment.
  function automatic logic [34:0] model(input logic [23:0] v, input logic [7:0] e,
                                        input logic [7:0] s);
    int si;
    int sum;
    logic [23:0] m;
    logic g, r, st;
    logic [7:0] ex;
    si = int'(s);
    m  = (si >= 24) ? 24'h0 : (v >> si);
    g  = (si >= 1 && si <= 24) ? v[si-1] : 1'b0;
    r  = (si >= 2 && si <= 25) ? v[si-2] : 1'b0;
    st = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (si >= 3 && i <= si - 3 && v[i]) st = 1'b1;
    end
    sum = int'(e) + si;
    ex  = (sum > 255) ? 8'hFF : sum[7:0];
    return {m, g, r, st, ex};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      mon_got = {bus.out_mant, bus.out_guard, bus.out_round, bus.out_sticky, bus.out_exp};
      if (sb.size() == 0) begin
        check("out_with_empty_scoreboard", 64'(bus.out_valid), 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("out_result", 64'(mon_got), 64'(mon_exp));
        if ((|mon_exp[10:8]) && stat_model < 65535) stat_model++;
        $display("xfer mant=%h g=%b r=%b s=%b exp=%h", bus.out_mant, bus.out_guard,
                 bus.out_round, bus.out_sticky, bus.out_exp);
      end
    end
  end

  task automatic send(input logic [23:0] m, input logic [7:0] e, input logic [7:0] s);
    int waitc;
    waitc = 0;
    bus.in_valid = 1'b1;
    bus.in_mant  = m;
    bus.in_exp   = e;
    bus.in_shift = s;
    @(negedge clk);
    while (!bus.in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) check("send_timeout", 64'(bus.in_ready), 64'd1);
    else sb.push_back(model(m, e, s));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && cnt < 200) begin
      @(posedge clk);
      cnt++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_stat();
`ifdef ALIGN_STAT_EN
    check("stat_inexact", 64'(stat_inexact), 64'(stat_model));
`endif
  endtask

  logic [23:0] d_m[6] = '{24'h800000, 24'hC00001, 24'h800000, 24'h800000, 24'hFFFFFF, 24'h000000};
  logic [7:0]  d_e[6] = '{8'd10, 8'd100, 8'd50, 8'd50, 8'd240, 8'd7};
  logic [7:0]  d_s[6] = '{8'd0, 8'd3, 8'd24, 8'd25, 8'd30, 8'd5};

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] exp_a;
    int stale;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_shift  = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_mant", 64'(bus.out_mant), 64'd0);
    check("rst_out_exp", 64'(bus.out_exp), 64'd0);
    check("rst_out_grs", 64'({bus.out_guard, bus.out_round, bus.out_sticky}), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_stat();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases, one at a time; the first also pins the two-cycle latency.
    for (int i = 0; i < 6; i++) begin
      send(d_m[i], d_e[i], d_s[i]);
      if (i == 0) begin
        check("latency_cycle1", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("latency_cycle2", 64'(bus.out_valid), 64'd1);
      end
      drain();
      check_stat();
    end

    // Backpressure: A and B fill the pipe, C waits, A held stable.
    bus.out_ready = 1'b0;
    exp_a = model(24'hABCDEF, 8'd20, 8'd4);
    fork
      begin
        send(24'hABCDEF, 8'd20, 8'd4);
        send(24'h123457, 8'd30, 8'd9);
        send(24'hFEDCBA, 8'd40, 8'd17);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_hold_a", 64'({bus.out_mant, bus.out_guard, bus.out_round, bus.out_sticky,
                                bus.out_exp}), 64'(exp_a));
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_no_gap", 64'(bus.out_valid), 64'd1);
        end
      end
    join
    drain();
    check_stat();

    // Random traffic with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [23:0] rm;
          logic [7:0]  rs;
          rm = (i % 10 == 0) ? 24'h0 : 24'($urandom);
          rs = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
          send(rm, 8'($urandom), rs);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    check_stat();

    // Reset with both stages occupied.
    bus.out_ready = 1'b0;
    send(24'h5A5A5A, 8'd1, 8'd6);
    send(24'h3C3C3C, 8'd2, 8'd12);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_mant", 64'(bus.out_mant), 64'd0);
    check("midrst_out_exp", 64'(bus.out_exp), 64'd0);
    check("midrst_out_grs", 64'({bus.out_guard, bus.out_round, bus.out_sticky}), 64'd0);
    sb.delete();
    stat_model = 0;
    check_stat();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("postrst_in_ready", 64'(bus.in_ready), 64'd1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("postrst_no_stale", 64'(stale), 64'd0);
    @(posedge clk);
    #1;
    send(24'hFFFFFF, 8'd240, 8'd30);
    drain();
    check_stat();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
